// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer exposing CTRL, PRESET and COUNT
// word registers, with a maskable interrupt raised when the count expires.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  ctrl;
  logic [3:0]  ctrl_next;
  logic [31:0] preset;
  logic [31:0] preset_next;
  logic [31:0] count;
  logic [31:0] count_next;
  logic        irq_flag;
  logic        irq_flag_next;

  logic [1:0]  sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en;
  logic        auto_reload;
  logic        unused_addr;

  assign sel         = Addr[3:2];
  assign wr_ctrl     = WE && (sel == 2'd0);
  assign wr_preset   = WE && (sel == 2'd1);
  assign en          = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_next;
      ctrl     <= ctrl_next;
      preset   <= preset_next;
      count    <= count_next;
      irq_flag <= irq_flag_next;
    end
  end

  // Order matters: a register write clears the flag first so that an expiry in
  // the same cycle can still set it, and the CPU's CTRL data overrides INT's EN clear.
  always_comb begin
    state_next    = state;
    ctrl_next     = ctrl;
    preset_next   = preset;
    count_next    = count;
    irq_flag_next = irq_flag;

    if (wr_ctrl || wr_preset) begin
      irq_flag_next = 1'b0;
    end

    case (state)
      IDLE: begin
        if (en) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        count_next = preset;
        state_next = CNT;
      end
      CNT: begin
        if (!en) begin
          state_next = IDLE;
        end else if (count > 32'd1) begin
          count_next = count - 32'd1;
        end else begin
          count_next    = 32'd0;
          irq_flag_next = 1'b1;
          state_next    = INT;
        end
      end
      INT: begin
        if (auto_reload) begin
          irq_flag_next = 1'b0;
        end else begin
          ctrl_next[0] = 1'b0;
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (wr_ctrl) begin
      ctrl_next = Din[3:0];
    end
    if (wr_preset) begin
      preset_next = Din;
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (sel)
      2'd0:    Dout = {28'd0, ctrl};
      2'd1:    Dout = preset;
      2'd2:    Dout = count;
      default: Dout = 32'd0;
    endcase
  end

  assign IRQ = ctrl[3] & irq_flag;

endmodule
